// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus the outgoing valid/ready stream of the read-side drain engine.
// The master modport is the drain engine; the slave modport is the FIFO plus the downstream sink.
interface fifo_rd_drain_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  rdata,
    input  rempty,
    input  m_ready,
    output rinc,
    output m_valid,
    output m_data
  );

  modport slave (
    output rdata,
    output rempty,
    output m_ready,
    input  rinc,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain drain engine: pops cmd_len words from a first-word fall-through FIFO
// and replays them on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  fifo_rd_drain_if.master      rd,
  input  logic                 cmd_start,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_abort,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] word_cnt
);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush, StDone} state_e;

  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  state_e                state_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [LEN_WIDTH-1:0]  pops_left_q;
  logic [LEN_WIDTH-1:0]  word_cnt_q;
  logic                  pop, xfer;

  // Pop depends only on registered state and rempty; m_ready never reaches rinc.
  assign pop  = (state_q == StDrain) && (pops_left_q != '0) && !rd.rempty && (occ_q != 2'd2);
  assign xfer = (occ_q != 2'd0) && rd.m_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({pop, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      pops_left_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      occ_q <= occ_d;

      // buf0 is always the oldest entry; a transfer from a full buffer shifts buf1 down.
      if (xfer) begin
        if (occ_q == 2'd2) begin
          buf0_q <= buf1_q;
          if (pop) buf1_q <= rd.rdata;
        end else if (pop) begin
          buf0_q <= rd.rdata;
        end
      end else if (pop) begin
        if (occ_q == 2'd0) buf0_q <= rd.rdata;
        else               buf1_q <= rd.rdata;
      end

      if (xfer) word_cnt_q <= word_cnt_q + LenOne;

      unique case (state_q)
        StIdle: begin
          if (cmd_start) begin
            word_cnt_q <= '0;
            if (cmd_len != '0) begin
              pops_left_q <= cmd_len;
              state_q     <= StDrain;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDrain: begin
          if (pop) pops_left_q <= pops_left_q - LenOne;
          if (cmd_abort) begin
            pops_left_q <= '0;
            state_q     <= StFlush;
          end else if (pop && pops_left_q == LenOne) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (occ_d == 2'd0) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd.rinc    = pop;
  assign rd.m_valid = (occ_q != 2'd0);
  assign rd.m_data  = buf0_q;
  assign busy       = (state_q == StDrain) || (state_q == StFlush);
  assign done       = (state_q == StDone);
  assign word_cnt   = word_cnt_q;

endmodule
